// File: rtl/tcam_add32_seq.sv
// tcam_add32_seq: 32-bit adder built by sequencing four byte-wide operations
// through an external 8-bit TCAM adder slice. It also forwards table-load
// writes to that slice.
// Optional feature macro: TCAM_SEQ_OVF_EN enables signed-overflow reporting on
// out_ovf. When the macro is undefined, out_ovf is tied to 0.
module tcam_add32_seq #(
  parameter int unsigned SLICE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  // add request
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_cin,
  // result
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_cout,
  output logic        out_ovf,
  // table load request
  input  logic        tbl_valid,
  output logic        tbl_ready,
  input  logic [6:0]  tbl_addr_in,
  input  logic [4:0]  tbl_data_in,
  // slice issue / return
  output logic [7:0]  slice_a,
  output logic [7:0]  slice_b,
  output logic        slice_cin,
  output logic        slice_vld,
  input  logic [8:0]  slice_sum,
  // slice table write port
  output logic        tbl_we,
  output logic [6:0]  tbl_addr,
  output logic [4:0]  tbl_data
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [1:0]         k;
  logic [CNT_W-1:0]   lat_cnt;
  logic [23:0]        sum_lo;
  logic               wait_last;

  // Select operand byte idx of a 32-bit word.
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [31:0] w,
                                                 input logic [1:0]  idx);
    logic [BYTE_W-1:0] r;
    case (idx)
      2'd0:    r = w[7:0];
      2'd1:    r = w[15:8];
      2'd2:    r = w[23:16];
      default: r = w[31:24];
    endcase
    return r;
  endfunction

  // Handshake readies: only in IDLE and never during reset; a pending table
  // load takes priority over an add request in the same cycle.
  assign tbl_ready = (state == IDLE) && !rst;
  assign in_ready  = (state == IDLE) && !rst && !tbl_valid;

  // Final WAIT cycle: the slice result is valid on slice_sum.
  assign wait_last = (lat_cnt == CNT_W'(SLICE_LAT - 1));

  // Sequencer: table loads, byte issue/capture, and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      k         <= '0;
      lat_cnt   <= '0;
      sum_lo    <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      slice_a   <= '0;
      slice_b   <= '0;
      slice_cin <= 1'b0;
      slice_vld <= 1'b0;
      tbl_we    <= 1'b0;
      tbl_addr  <= '0;
      tbl_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tbl_valid) begin
            tbl_addr <= tbl_addr_in;
            tbl_data <= tbl_data_in;
            tbl_we   <= 1'b1;
            state    <= LOAD;
          end else if (in_valid) begin
            a_q       <= in_a;
            b_q       <= in_b;
            k         <= 2'd0;
            slice_a   <= in_a[7:0];
            slice_b   <= in_b[7:0];
            slice_cin <= in_cin;
            slice_vld <= 1'b1;
            state     <= ISSUE;
          end
        end

        LOAD: begin
          tbl_we <= 1'b0;
          state  <= IDLE;
        end

        ISSUE: begin
          slice_vld <= 1'b0;
          lat_cnt   <= '0;
          state     <= WAIT;
        end

        WAIT: begin
          if (wait_last) begin
            if (k == 2'd3) begin
              out_sum   <= {slice_sum[7:0], sum_lo};
              out_cout  <= slice_sum[8];
`ifdef TCAM_SEQ_OVF_EN
              out_ovf   <= (a_q[31] == b_q[31]) && (slice_sum[7] != a_q[31]);
`else
              out_ovf   <= 1'b0;
`endif
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              case (k)
                2'd0:    sum_lo[7:0]   <= slice_sum[7:0];
                2'd1:    sum_lo[15:8]  <= slice_sum[7:0];
                default: sum_lo[23:16] <= slice_sum[7:0];
              endcase
              k         <= k + 2'd1;
              slice_a   <= byte_sel(a_q, k + 2'd1);
              slice_b   <= byte_sel(b_q, k + 2'd1);
              slice_cin <= slice_sum[8];
              slice_vld <= 1'b1;
              state     <= ISSUE;
            end
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcam_add32_seq.sv
// Directed bench for tcam_add32_seq with an ideal one-cycle slice model.
module tb_tcam_add32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic        in_cin;
  logic        out_valid, out_ready;
  logic [31:0] out_sum;
  logic        out_cout, out_ovf;
  logic        tbl_valid, tbl_ready;
  logic [6:0]  tbl_addr_in;
  logic [4:0]  tbl_data_in;
  logic [7:0]  slice_a, slice_b;
  logic        slice_cin, slice_vld;
  logic [8:0]  slice_sum = '0;
  logic        tbl_we;
  logic [6:0]  tbl_addr;
  logic [4:0]  tbl_data;

  int n_pass = 0;
  int n_chk  = 0;

  bit cin_log [0:255];
  int cin_n = 0;

`ifdef TCAM_SEQ_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  tcam_add32_seq #(.SLICE_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .tbl_valid(tbl_valid), .tbl_ready(tbl_ready),
    .tbl_addr_in(tbl_addr_in), .tbl_data_in(tbl_data_in),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_vld(slice_vld), .slice_sum(slice_sum),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data)
  );

  always #5 clk = ~clk;

  // Ideal slice: result one cycle after the issue strobe.
  always @(posedge clk)
    if (slice_vld) slice_sum <= 9'(slice_a) + 9'(slice_b) + 9'(slice_cin);

  // Record carry-in of every issued byte.
  always @(negedge clk)
    if (slice_vld) begin
      cin_log[cin_n % 256] = slice_cin;
      cin_n = cin_n + 1;
    end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic start_add(input logic [31:0] a, input logic [31:0] b, input logic cin);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    #1 check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_latency"}, 64'(n + 1), 64'd9);
  endtask

  task automatic check_res(input string tag, input logic [31:0] s, input logic c, input logic o);
    check({tag, "_sum"},  64'(out_sum),  64'(s));
    check({tag, "_cout"}, 64'(out_cout), 64'(c));
    check({tag, "_ovf"},  64'(out_ovf),  64'(o));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int base;
    bit seen;
    rst = 1'b1; in_valid = 0; in_a = '0; in_b = '0; in_cin = 0;
    out_ready = 0; tbl_valid = 0; tbl_addr_in = '0; tbl_data_in = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_tbl_ready", 64'(tbl_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_slice_vld", 64'(slice_vld), 64'd0);
    check("rst_tbl_we",    64'(tbl_we),    64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_out_cout",  64'(out_cout),  64'd0);
    check("rst_out_ovf",   64'(out_ovf),   64'd0);
    check("rst_slice_ab",  64'({slice_a, slice_b, slice_cin}), 64'd0);
    rst = 1'b0;
    #1 check("idle_in_ready",  64'(in_ready),  64'd1);
    check("idle_tbl_ready", 64'(tbl_ready), 64'd1);

    // Byte-0 carry ripple into byte 1
    start_add(32'h0000_00FF, 32'h0000_0001, 1'b0);
    check("busy_in_ready", 64'(in_ready), 64'd0);
    wait_valid("ff_p1");
    check_res("ff_p1", 32'h0000_0100, 1'b0, 1'b0);
    release_out("ff_p1");

    // Full carry chain, carry-in observed on bytes 1..3
    base = cin_n;
    start_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_valid("all_ones");
    check_res("all_ones", 32'h0000_0000, 1'b1, 1'b0);
    check("cin_byte0", 64'(cin_log[base % 256]),       64'd0);
    check("cin_byte1", 64'(cin_log[(base + 1) % 256]), 64'd1);
    check("cin_byte2", 64'(cin_log[(base + 2) % 256]), 64'd1);
    check("cin_byte3", 64'(cin_log[(base + 3) % 256]), 64'd1);
    check("slice_hold", 64'({slice_vld, slice_a, slice_b}), 64'({1'b0, 8'hFF, 8'h00}));
    release_out("all_ones");

    // Signed overflow positive + positive
    start_add(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_valid("ovf_pos");
    check_res("ovf_pos", 32'h8000_0000, 1'b0, OVF_ON);
    release_out("ovf_pos");

    // Negative + negative overflow with carry-out
    start_add(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_valid("ovf_neg");
    check_res("ovf_neg", 32'h0000_0000, 1'b1, OVF_ON);
    release_out("ovf_neg");

    // Mixed bytes with carry-in, plus output backpressure
    start_add(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    wait_valid("mixed");
    check_res("mixed", 32'hACF1_3569, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_sum", 64'(out_sum), 64'h0000_0000_ACF1_3569);
    end
    release_out("mixed");

    // Table load and add requested together: load wins
    @(negedge clk);
    tbl_valid = 1'b1; tbl_addr_in = 7'h05; tbl_data_in = 5'h1A;
    in_valid = 1'b1; in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_cin = 1'b0;
    #1 check("coll_in_ready",  64'(in_ready),  64'd0);
    check("coll_tbl_ready", 64'(tbl_ready), 64'd1);
    @(posedge clk);
    #1 tbl_valid = 1'b0;
    check("load_we",   64'(tbl_we),    64'd1);
    check("load_addr", 64'(tbl_addr),  64'h05);
    check("load_data", 64'(tbl_data),  64'h1A);
    check("load_busy", 64'(in_ready),  64'd0);
    check("load_nvld", 64'(slice_vld), 64'd0);
    @(posedge clk);
    #1 check("load_we_drop", 64'(tbl_we), 64'd0);
    check("post_load_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("add_we_low", 64'(tbl_we), 64'd0);
    wait_valid("coll");
    check_res("coll", 32'h3333_3333, 1'b0, 1'b0);
    release_out("coll");

    // Reset during WAIT of byte 2 discards the add
    start_add(32'h0102_0304, 32'h1020_3040, 1'b0);
    repeat (5) @(posedge clk);
    #1 check("mid_wait_vld", 64'(slice_vld), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1 check("mid_rst_idle", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    check("discard_no_valid", 64'(seen), 64'd0);

    // Add after reset recovery
    start_add(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
    wait_valid("post_rst");
    check_res("post_rst", 32'h0000_0000, 1'b1, 1'b0);
    release_out("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tcam_add32_seq.md
TCAM_ADD32_SEQ -- requirements
Module: tcam_add32_seq

Interface
REQ-001 Parameter SLICE_LAT, default 1, cycles from slice issue to valid slice_sum (range 1-7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid / in_ready  input / output  1 / 1  32-bit add request handshake.
REQ-005 in_a, in_b  input  32 each  operands; in_cin  input  1  carry-in.
REQ-006 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-007 out_sum  output  32  sum; out_cout  output  1  carry-out; out_ovf  output  1  signed overflow.
REQ-008 tbl_valid / tbl_ready  input / output  1 / 1  TCAM table-load handshake.
REQ-009 tbl_addr_in  input  7  entry index; tbl_data_in  input  5  entry data.
REQ-010 slice_a, slice_b  output  8 each  operand bytes to the 8-bit TCAM adder slice; slice_cin  output  1.
REQ-011 slice_vld  output  1  one-cycle issue strobe to the slice.
REQ-012 slice_sum  input  9  {carry, sum[7:0]} from the slice.
REQ-013 tbl_we  output  1; tbl_addr  output  7; tbl_data  output  5  table write port to the slice.

Function
REQ-014 The FSM states SHALL be IDLE, LOAD, ISSUE, WAIT, DONE.
REQ-015 in_ready and tbl_ready SHALL be high only in IDLE.
REQ-016 If tbl_valid and in_valid are both high in IDLE, the table load SHALL win; in_ready SHALL be low that cycle.
REQ-017 Accepted load: IDLE->LOAD. LOAD drives tbl_we=1 for exactly one cycle with the registered addr/data, then returns to IDLE.
REQ-018 Accepted add: register in_a, in_b, in_cin; clear byte index k=0; go to ISSUE.
REQ-019 ISSUE (one cycle) SHALL drive slice_vld=1, slice_a=a[8k+7:8k], slice_b=b[8k+7:8k], slice_cin = in_cin for k=0, otherwise the stored carry; then go to WAIT.
REQ-020 WAIT SHALL last SLICE_LAT cycles; on its last cycle, capture slice_sum[7:0] into result byte k and slice_sum[8] into the stored carry.
REQ-021 After capture: if k<3, increment k and go to ISSUE; if k=3, go to DONE.
REQ-022 Accept-to-out_valid latency SHALL be 4*(1+SLICE_LAT)+1 cycles (9 for SLICE_LAT=1).
REQ-023 DONE holds out_valid=1 with stable out_sum/out_cout/out_ovf until out_ready=1; it returns to IDLE the cycle after out_valid&out_ready.
REQ-024 out_cout SHALL equal the carry captured for byte 3.
REQ-025 slice_a/slice_b/slice_cin SHALL hold their last issued values when slice_vld=0.
REQ-026 tbl_we SHALL never be asserted in ISSUE, WAIT or DONE; slice_vld SHALL never be asserted in LOAD.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL enter IDLE regardless of state, including mid-operation.
REQ-028 Reset values: out_valid=0, in_ready=0 during reset, tbl_ready=0 during reset, slice_vld=0, tbl_we=0, out_sum=0, out_cout=0, out_ovf=0, slice_a/b=0, slice_cin=0, k=0.
REQ-029 An in-flight add interrupted by reset SHALL be discarded and SHALL produce no out_valid.

Configuration
REQ-030 Macro TCAM_SEQ_OVF_EN: when defined, out_ovf SHALL equal (a[31]==b[31]) && (sum[31]!=a[31]), registered with out_sum.
REQ-031 When TCAM_SEQ_OVF_EN is undefined, out_ovf SHALL be tied to 0; the port list is unchanged.

Verification
REQ-032 SLICE_LAT=1, ideal slice model. Add 0x000000FF+0x00000001, cin=0 -> out_sum=0x00000100, cout=0, out_valid 9 cycles after accept.
REQ-033 Add 0xFFFFFFFF+0x00000001, cin=0 -> out_sum=0x00000000, cout=1; slice_cin=1 observed on bytes 1-3.
REQ-034 With TCAM_SEQ_OVF_EN, add 0x7FFFFFFF+0x00000001 -> out_ovf=1, out_sum=0x80000000. Without the macro -> out_ovf=0.
REQ-035 tbl_valid and in_valid asserted together in IDLE (addr=0x05, data=0x1A) -> tbl_we one cycle with 0x05/0x1A; the add is accepted afterwards and completes correctly.
REQ-036 out_ready held low 5 cycles -> out_valid and out_sum stable; rst asserted during WAIT of byte 2 -> IDLE next cycle, no out_valid, next add correct.
